// File: rtl/ac_logic_unit_if.sv
// Request/status bundle between the control unit and the AC logic unit.
// Signal names follow the datapath's register-transfer names.
interface ac_logic_unit_if #(
  parameter int WIDTH = 16
);
  logic             OP_VALID;
  logic [2:0]       OP;
  logic             CLR_AC;
  logic [WIDTH-1:0] DR;
  logic             E;
  logic             CLR_OVF;
  logic [WIDTH-1:0] AC;
  logic [1:0]       CNTRL_E;
  logic             AC_ZERO;
  logic             AC_SIGN;
  logic             DONE;
  logic             OVF;

  modport master (
    output OP_VALID, OP, CLR_AC, DR, E, CLR_OVF,
    input  AC, CNTRL_E, AC_ZERO, AC_SIGN, DONE, OVF
  );

  modport slave (
    input  OP_VALID, OP, CLR_AC, DR, E, CLR_OVF,
    output AC, CNTRL_E, AC_ZERO, AC_SIGN, DONE, OVF
  );
endinterface

// File: rtl/ac_logic_unit.sv
// Accumulator plus adder/logic unit; one AC micro-op per accepted request.
// Optional sticky signed-overflow flag enabled by defining AC_OVF_FLAG_EN.
module ac_logic_unit #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  ac_logic_unit_if.slave bus
);

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_AND = 3'b001,
    OP_ADD = 3'b010,
    OP_LDA = 3'b011,
    OP_CMA = 3'b100,
    OP_CIR = 3'b101,
    OP_CIL = 3'b110,
    OP_INC = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    E_HOLD  = 2'b00,
    E_CLEAR = 2'b01,
    E_SET   = 2'b10
  } e_ctrl_e;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  logic [WIDTH-1:0] ac_q;
  logic [WIDTH-1:0] ac_next;
  logic             done_q;
  logic             done_next;
  logic             ovf_set;
  logic [WIDTH:0]   sum;
  e_ctrl_e          e_ctrl;
  op_e              op;

  assign op  = op_e'(bus.OP);
  assign sum = {1'b0, ac_q} + {1'b0, bus.DR};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    ac_next   = ac_q;
    done_next = 1'b0;
    e_ctrl    = E_HOLD;
    ovf_set   = 1'b0;
    if (rst) begin
      ac_next = '0;
    end else if (bus.CLR_AC) begin
      ac_next   = '0;
      done_next = 1'b1;
    end else if (bus.OP_VALID) begin
      done_next = 1'b1;
      unique case (op)
        OP_NOP: ac_next = ac_q;
        OP_AND: ac_next = ac_q & bus.DR;
        OP_ADD: begin
          ac_next = sum[WIDTH-1:0];
          e_ctrl  = sum[WIDTH] ? E_SET : E_CLEAR;
          ovf_set = (ac_q[WIDTH-1] == bus.DR[WIDTH-1]) &&
                    (sum[WIDTH-1] != ac_q[WIDTH-1]);
        end
        OP_LDA: ac_next = bus.DR;
        OP_CMA: ac_next = ~ac_q;
        OP_CIR: begin
          ac_next = {bus.E, ac_q[WIDTH-1:1]};
          e_ctrl  = ac_q[0] ? E_SET : E_CLEAR;
        end
        OP_CIL: begin
          ac_next = {ac_q[WIDTH-2:0], bus.E};
          e_ctrl  = ac_q[WIDTH-1] ? E_SET : E_CLEAR;
        end
        OP_INC: begin
          ac_next = ac_q + 1'b1;
          ovf_set = (ac_q == MAX_POS);
        end
        default: ac_next = ac_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (rst) begin
      ac_q   <= '0;
      done_q <= 1'b0;
    end else begin
      ac_q   <= ac_next;
      done_q <= done_next;
    end
  end

`ifdef AC_OVF_FLAG_EN
  logic ovf_q;

  // A new overflow in the same cycle as CLR_OVF wins over the clear.
  always_ff @(posedge clk) begin
    if (rst)              ovf_q <= 1'b0;
    else if (ovf_set)     ovf_q <= 1'b1;
    else if (bus.CLR_OVF) ovf_q <= 1'b0;
  end

  assign bus.OVF = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = bus.CLR_OVF ^ ovf_set;
  assign bus.OVF    = 1'b0;
`endif

  assign bus.AC      = ac_q;
  assign bus.CNTRL_E = e_ctrl;
  assign bus.AC_ZERO = (ac_q == '0);
  assign bus.AC_SIGN = ac_q[WIDTH-1];
  assign bus.DONE    = done_q;

endmodule

// File: tb/tb_ac_logic_unit.sv
// Directed bench for ac_logic_unit: expected post-edge state is queued at
// drive time and popped after the edge; CNTRL_E is checked before the edge.
module tb_ac_logic_unit;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] ac;
    logic         done;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [W-1:0] m_ac  = '0;
  logic         m_ovf = 1'b0;
  exp_t         sb[$];

  ac_logic_unit_if #(.WIDTH(W)) bus ();

  ac_logic_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive after negedge, check CNTRL_E, then check state after posedge.
  task automatic step(input string tag, input logic r, input logic clr, input logic valid,
                      input logic [2:0] op, input logic [W-1:0] dr, input logic e,
                      input logic clr_ovf);
    logic [W-1:0] nxt;
    logic [W:0]   s;
    logic [1:0]   ce;
    logic         ovf_set;
    logic         done;
    exp_t         x;
    exp_t         got;
    @(negedge clk);
    rst = r; bus.CLR_AC = clr; bus.OP_VALID = valid; bus.OP = op;
    bus.DR = dr; bus.E = e; bus.CLR_OVF = clr_ovf;
    nxt = m_ac; ce = 2'b00; ovf_set = 1'b0; done = 1'b0;
    s = {1'b0, m_ac} + {1'b0, dr};
    if (r) begin
      nxt = '0;
    end else if (clr) begin
      nxt = '0; done = 1'b1;
    end else if (valid) begin
      done = 1'b1;
      case (op)
        3'b001: nxt = m_ac & dr;
        3'b010: begin
          nxt = s[W-1:0];
          ce = s[W] ? 2'b10 : 2'b01;
          ovf_set = (m_ac[W-1] == dr[W-1]) && (s[W-1] != m_ac[W-1]);
        end
        3'b011: nxt = dr;
        3'b100: nxt = ~m_ac;
        3'b101: begin nxt = {e, m_ac[W-1:1]}; ce = m_ac[0] ? 2'b10 : 2'b01; end
        3'b110: begin nxt = {m_ac[W-2:0], e}; ce = m_ac[W-1] ? 2'b10 : 2'b01; end
        3'b111: begin nxt = m_ac + 16'd1; ovf_set = (m_ac == 16'h7FFF); end
        default: nxt = m_ac;
      endcase
    end
`ifdef AC_OVF_FLAG_EN
    if (r)             m_ovf = 1'b0;
    else if (ovf_set)  m_ovf = 1'b1;
    else if (clr_ovf)  m_ovf = 1'b0;
`else
    m_ovf = 1'b0;
`endif
    m_ac = nxt;
    x.ac = nxt; x.done = done; x.ovf = m_ovf;
    sb.push_back(x);
    #1;
    check({tag, ".cntrl_e"}, W'(bus.CNTRL_E), W'(ce));
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({tag, ".ac"},      bus.AC,           got.ac);
    check({tag, ".done"},    W'(bus.DONE),     W'(got.done));
    check({tag, ".ovf"},     W'(bus.OVF),      W'(got.ovf));
    check({tag, ".ac_zero"}, W'(bus.AC_ZERO),  W'(got.ac == '0));
    check({tag, ".ac_sign"}, W'(bus.AC_SIGN),  W'(got.ac[W-1]));
  endtask

  initial begin
    rst = 1'b1;
    bus.CLR_AC = 1'b0; bus.OP_VALID = 1'b0; bus.OP = 3'b000;
    bus.DR = '0; bus.E = 1'b0; bus.CLR_OVF = 1'b0;

    // Reset held two cycles with a live LDA request.
    step("rst0", 1, 0, 1, 3'b011, 16'h1234, 0, 0);
    step("rst1", 1, 0, 1, 3'b011, 16'h1234, 0, 0);
    check("rst_ac_literal", bus.AC, 16'h0000);
    step("idle", 0, 0, 0, 3'b011, 16'h1234, 0, 0);

    // ADD with carry out, then without.
    step("lda_ffff", 0, 0, 1, 3'b011, 16'hFFFF, 0, 0);
    step("add_carry", 0, 0, 1, 3'b010, 16'h0001, 0, 0);
    check("add_carry_zero_literal", W'(bus.AC_ZERO), 16'd1);
    step("add_nocarry", 0, 0, 1, 3'b010, 16'h0005, 0, 0);
    check("add_nocarry_literal", bus.AC, 16'h0005);

    // Logic ops and NOP.
    step("lda_f0f0", 0, 0, 1, 3'b011, 16'hF0F0, 0, 0);
    step("and", 0, 0, 1, 3'b001, 16'h3CC3, 0, 0);
    check("and_literal", bus.AC, 16'h30C0);
    step("cma", 0, 0, 1, 3'b100, 16'h0000, 0, 0);
    step("nop", 0, 0, 1, 3'b000, 16'hFFFF, 1, 0);

    // Rotates through E.
    step("lda_8001", 0, 0, 1, 3'b011, 16'h8001, 0, 0);
    step("cil", 0, 0, 1, 3'b110, 16'h0000, 0, 0);
    check("cil_literal", bus.AC, 16'h0002);
    step("cir", 0, 0, 1, 3'b101, 16'h0000, 1, 0);
    check("cir_literal", bus.AC, 16'h8001);

    // CLR_AC beats a simultaneous LDA; DONE pulses once.
    step("cla_prio", 0, 1, 1, 3'b011, 16'hABCD, 0, 0);
    step("cla_after", 0, 0, 0, 3'b000, 16'hABCD, 0, 0);

    // Back-to-back INC through wrap.
    step("lda_fffe", 0, 0, 1, 3'b011, 16'hFFFE, 0, 0);
    step("inc1", 0, 0, 1, 3'b111, 16'h0000, 1, 0);
    step("inc2", 0, 0, 1, 3'b111, 16'h0000, 1, 0);
    check("inc_wrap_literal", bus.AC, 16'h0000);
    step("inc3", 0, 0, 1, 3'b111, 16'h0000, 1, 0);
    step("inc_idle", 0, 0, 0, 3'b111, 16'h0000, 0, 0);

    // Signed overflow flag behaviour (constant 0 without the feature).
    step("lda_7fff", 0, 0, 1, 3'b011, 16'h7FFF, 0, 0);
    step("add_ovf", 0, 0, 1, 3'b010, 16'h0001, 0, 0);
`ifdef AC_OVF_FLAG_EN
    check("add_ovf_literal", W'(bus.OVF), 16'd1);
`endif
    step("lda_1", 0, 0, 1, 3'b011, 16'h0001, 0, 0);
    step("add_1_1", 0, 0, 1, 3'b010, 16'h0001, 0, 0);
    step("cla_keeps_ovf", 0, 1, 0, 3'b000, 16'h0000, 0, 0);
    step("clr_ovf", 0, 0, 0, 3'b000, 16'h0000, 0, 1);
    check("clr_ovf_literal", W'(bus.OVF), 16'd0);
    step("lda_7fff_b", 0, 0, 1, 3'b011, 16'h7FFF, 0, 0);
    step("inc_ovf_set_wins", 0, 0, 1, 3'b111, 16'h0000, 0, 1);
    step("mid_reset", 1, 0, 1, 3'b010, 16'h7FFF, 0, 0);
    step("post_reset", 0, 0, 0, 3'b000, 16'h0000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
